// File: rtl/alu_ctrl_decode_reg_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode_reg_pkg
//
// Shared definitions for the decode-side ALU control path:
//   - aluCtrl_e  : 4-bit ALU operation code consumed by the execute-stage ALU
//                  and produced by the main decoder.
//   - OP_* / F_* : MIPS opcode (InstrD[31:26]) and R-type funct (InstrD[5:0])
//                  encodings recognised by this lane.
//   - eCtrl_t    : control bundle carried across the ID/EX boundary.
//   - CTRL_BUBBLE / CTRL_ILLEGAL : the two canned bundle values.
// -----------------------------------------------------------------------------
package alu_ctrl_decode_reg_pkg;

   // ALU operation codes. ALU_NONE marks a slot holding an undecodable
   // instruction so the ALU never performs a meaningful operation for it.
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_NOR  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_LUI  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_NONE = 4'b1111
   } aluCtrl_e;

   // Primary opcodes, InstrD[31:26].
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes, InstrD[5:0].
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   // Control bundle carried from Decode into Execute.
   typedef struct packed {
      aluCtrl_e aluCtrl;   // ALU operation
      logic     aluSrc;    // SrcB from immediate
      logic     zeroExt;   // zero-extend imm16 (logical immediates)
      logic     lui;       // datapath drives {imm16,16'b0} onto SrcA
      logic     regDst;    // destination is rd (R-type) rather than rt
      logic     valid;     // slot holds a real, decodable instruction
      logic     illegal;   // a real instruction with an unsupported encoding
   } eCtrl_t;

   // Empty slot: nothing executes, nothing is flagged.
   localparam eCtrl_t CTRL_BUBBLE = '{
      aluCtrl : ALU_AND,
      aluSrc  : 1'b0,
      zeroExt : 1'b0,
      lui     : 1'b0,
      regDst  : 1'b0,
      valid   : 1'b0,
      illegal : 1'b0
   };

   // Unsupported encoding: slot is killed but the event is made visible.
   localparam eCtrl_t CTRL_ILLEGAL = '{
      aluCtrl : ALU_NONE,
      aluSrc  : 1'b0,
      zeroExt : 1'b0,
      lui     : 1'b0,
      regDst  : 1'b0,
      valid   : 1'b0,
      illegal : 1'b1
   };

endpackage : alu_ctrl_decode_reg_pkg

// File: rtl/alu_ctrl_decode_comb.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode_comb
//
// Pure combinational decode of a MIPS opcode/funct pair into the ID/EX control
// bundle. No state.
//
// Ports:
//   op     in  6        InstrD[31:26]
//   funct  in  6        InstrD[5:0]
//   valid  in  1        the instruction word is real (else a bubble is produced)
//   ctrl   out eCtrl_t  decoded control bundle
// -----------------------------------------------------------------------------
module alu_ctrl_decode_comb
   import alu_ctrl_decode_reg_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       valid,
   output eCtrl_t     ctrl
);

   logic isLegal;

   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path
      // through the case statements can leave it unassigned and infer a latch.
      ctrl    = CTRL_BUBBLE;
      isLegal = 1'b1;

      case (op)
         OP_RTYPE: begin
            ctrl.regDst = 1'b1;
            case (funct)
               F_ADD, F_ADDU: ctrl.aluCtrl = ALU_ADD;
               F_SUB, F_SUBU: ctrl.aluCtrl = ALU_SUB;
               F_AND:         ctrl.aluCtrl = ALU_AND;
               F_OR:          ctrl.aluCtrl = ALU_OR;
               F_XOR:         ctrl.aluCtrl = ALU_XOR;
               F_NOR:         ctrl.aluCtrl = ALU_NOR;
               F_SLT:         ctrl.aluCtrl = ALU_SLT;
               F_SLTU:        ctrl.aluCtrl = ALU_SLTU;
               default:       isLegal      = 1'b0;
            endcase
         end

         // Address generation shares the adder with the add-immediates.
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.aluCtrl = ALU_ADD;
         end

         OP_SLTI: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.aluCtrl = ALU_SLT;
         end

         OP_SLTIU: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.aluCtrl = ALU_SLTU;
         end

         // Logical immediates zero-extend imm16.
         OP_ANDI: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.zeroExt = 1'b1;
            ctrl.aluCtrl = ALU_AND;
         end

         OP_ORI: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.zeroExt = 1'b1;
            ctrl.aluCtrl = ALU_OR;
         end

         OP_XORI: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.zeroExt = 1'b1;
            ctrl.aluCtrl = ALU_XOR;
         end

         // The shifted immediate is placed on SrcA by the datapath; the ALU
         // just passes it through.
         OP_LUI: begin
            ctrl.aluSrc  = 1'b1;
            ctrl.lui     = 1'b1;
            ctrl.aluCtrl = ALU_LUI;
         end

         // Branch compare: subtract two registers, destination irrelevant.
         OP_BEQ, OP_BNE: begin
            ctrl.aluCtrl = ALU_SUB;
         end

         default: isLegal = 1'b0;
      endcase

      if (isLegal) begin
         ctrl.valid = 1'b1;
      end else begin
         ctrl = CTRL_ILLEGAL;
      end

      // A non-instruction is a plain bubble regardless of its bit pattern.
      if (!valid) begin
         ctrl = CTRL_BUBBLE;
      end
   end

endmodule : alu_ctrl_decode_comb

// File: rtl/alu_ctrl_decode_reg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode_reg
//
// Decode-side producer of the ALU control code and operand-steering controls
// for one issue lane, registered as the ID/EX boundary. Per edge the E
// register is loaded with a bubble (FlushE), held (StallE) or loaded with the
// decode of InstrD, in that priority order. Unsupported encodings with
// ValidD high are killed and flagged on IllegalE.
//
// Build option: define ALU_DECODE_STATS_EN to add a saturating count of
// illegal instructions loaded into E, exposed on IllegalCntE.
//
// Parameters:
//   CNT_W        width of the illegal-instruction counter (stats build only)
//
// Ports:
//   clk          in   1      pipeline clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   InstrD       in   32     instruction word in Decode
//   ValidD       in   1      InstrD holds a real instruction
//   StallE       in   1      hold all E-stage outputs
//   FlushE       in   1      load a bubble into E
//   ALUCtrlE     out  4      ALU operation code
//   ALUSrcE      out  1      SrcB from immediate
//   ZeroExtE     out  1      zero-extend imm16, else sign-extend
//   LuiE         out  1      datapath drives {imm16,16'b0} onto SrcAE
//   RegDstE      out  1      rd destination (R-type), else rt
//   ValidE       out  1      E slot holds a real instruction
//   IllegalE     out  1      E slot holds an unsupported instruction
//   IllegalCntE  out  CNT_W  saturating illegal count (ALU_DECODE_STATS_EN)
// -----------------------------------------------------------------------------
module alu_ctrl_decode_reg
   import alu_ctrl_decode_reg_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       InstrD,
   input  logic              ValidD,
   input  logic              StallE,
   input  logic              FlushE,
   output logic [3:0]        ALUCtrlE,
   output logic              ALUSrcE,
   output logic              ZeroExtE,
   output logic              LuiE,
   output logic              RegDstE,
   output logic              ValidE,
   output logic              IllegalE
`ifdef ALU_DECODE_STATS_EN
   ,
   output logic [CNT_W-1:0]  IllegalCntE
`endif
);

   eCtrl_t decCtrl;
   eCtrl_t eReg;

   // Register and immediate fields are decoded by other units of the lane.
   logic unusedInstrBits;
   assign unusedInstrBits = ^InstrD[25:6];

   alu_ctrl_decode_comb uDecode (
      .op    (InstrD[31:26]),
      .funct (InstrD[5:0]),
      .valid (ValidD),
      .ctrl  (decCtrl)
   );

   // E register: flush beats stall, stall beats load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: nonblocking assignments for all state, so every flop samples
         // the pre-edge values regardless of process ordering.
         eReg <= CTRL_BUBBLE;
      end else if (FlushE) begin
         eReg <= CTRL_BUBBLE;
      end else if (!StallE) begin
         eReg <= decCtrl;
      end
   end

   assign ALUCtrlE = eReg.aluCtrl;
   assign ALUSrcE  = eReg.aluSrc;
   assign ZeroExtE = eReg.zeroExt;
   assign LuiE     = eReg.lui;
   assign RegDstE  = eReg.regDst;
   assign ValidE   = eReg.valid;
   assign IllegalE = eReg.illegal;

`ifdef ALU_DECODE_STATS_EN
   logic [CNT_W-1:0] illegalCnt;
   logic             loadIllegal;

   // Counts only edges that actually place an illegal instruction into E.
   assign loadIllegal = decCtrl.illegal & ~StallE & ~FlushE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegalCnt <= '0;
      end else if (loadIllegal && (illegalCnt != {CNT_W{1'b1}})) begin
         illegalCnt <= illegalCnt + 1'b1;
      end
   end

   assign IllegalCntE = illegalCnt;
`endif

endmodule : alu_ctrl_decode_reg
